// File: rtl/bp_update_scheduler_if.sv
// bp_update_scheduler_if: shared BTB/gshare write-port bus; the scheduler is master, the tables are slave.
interface bp_update_scheduler_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 9
);
  logic                  valid;
  logic                  ready;
  logic                  clear;
  logic [INDEX_BITS-1:0] index;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] target;
  logic                  taken;
  modport master (output valid, clear, index, pc, target, taken, input ready);
  modport slave  (input valid, clear, index, pc, target, taken, output ready);
endinterface

// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: funnels 2-wide branch feedback through a FIFO into the shared BTB/gshare write port and owns the table clear walk.
// Define BP_UPD_STATS_EN to add saturating drop_count_o/upd_count_o counters.
module bp_update_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int INDEX_BITS = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                fb_valid_i,
  input  logic [1:0][ADDR_WIDTH-1:0] fb_pc_i,
  input  logic [1:0][ADDR_WIDTH-1:0] fb_target_i,
  input  logic [1:0]                fb_taken_i,
  input  logic [1:0]                fb_mispredict_i,
  input  logic                      clear_req_i,
  bp_update_scheduler_if.master     upd,
  output logic                      pred_stall_o,
  output logic                      drop_pulse_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
`ifdef BP_UPD_STATS_EN
  ,
  output logic [15:0]               drop_count_o,
  output logic [15:0]               upd_count_o
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  typedef enum logic {INIT, RUN} state_t;
  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] clear_idx_q, clear_idx_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_ptr;
  logic [CW-1:0]         count_q, count_d, space;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] pc_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] target_mem [FIFO_DEPTH];
  logic                  taken_mem [FIFO_DEPTH];
  logic                  acc0, acc1, push0, push1, pop, flush, in_init;
  logic [1:0]            n_push, n_drop;
  logic                  unused_mispredict1;
  assign unused_mispredict1 = fb_mispredict_i[1];
  always_comb begin
    in_init = state_q == INIT;
    acc0 = fb_valid_i[0];
    acc1 = fb_valid_i[1] && !(fb_valid_i[0] && fb_mispredict_i[0]);
    space = DEPTH - count_q;
    flush = !in_init && clear_req_i;
    pop = !in_init && count_q != '0 && upd.ready;
    // free space comes from the registered count, so a same-cycle pop never makes room
    push0 = !flush && acc0 && space != '0;
    push1 = !flush && acc1 && space >= (acc0 ? CW'(2) : CW'(1));
    n_push = 2'(push0) + 2'(push1);
    n_drop = flush ? 2'd0 : 2'(acc0) + 2'(acc1) - n_push;
    wr1_ptr = wr_ptr_q + PW'(push0);
    count_d = flush ? '0 : count_q + CW'(n_push) - CW'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(n_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    drop_d = n_drop != 2'd0;
    state_d = state_q;
    clear_idx_d = clear_idx_q;
    if (in_init) begin
      if (upd.ready) begin
        clear_idx_d = clear_idx_q + INDEX_BITS'(1);
        state_d = &clear_idx_q ? RUN : INIT;
      end
    end else if (clear_req_i) begin
      state_d = INIT;
      clear_idx_d = '0;
    end
  end
  always_comb begin
    upd.valid = in_init || count_q != '0;
    upd.clear = in_init;
    upd.index = in_init ? clear_idx_q : '0;
    upd.pc = in_init ? '0 : pc_mem[rd_ptr_q];
    upd.target = in_init ? '0 : target_mem[rd_ptr_q];
    upd.taken = in_init ? 1'b0 : taken_mem[rd_ptr_q];
    pred_stall_o = in_init;
    drop_pulse_o = drop_q;
    fifo_count_o = count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      clear_idx_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_idx_q <= clear_idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push0) begin
      pc_mem[wr_ptr_q] <= fb_pc_i[0];
      target_mem[wr_ptr_q] <= fb_target_i[0];
      taken_mem[wr_ptr_q] <= fb_taken_i[0];
    end
    if (push1) begin
      pc_mem[wr1_ptr] <= fb_pc_i[1];
      target_mem[wr1_ptr] <= fb_target_i[1];
      taken_mem[wr1_ptr] <= fb_taken_i[1];
    end
  end
`ifdef BP_UPD_STATS_EN
  logic [15:0] drop_cnt_q, upd_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      upd_cnt_q <= '0;
    end else begin
      drop_cnt_q <= (drop_cnt_q > 16'hFFFF - 16'(n_drop)) ? 16'hFFFF : drop_cnt_q + 16'(n_drop);
      upd_cnt_q <= (pop && upd_cnt_q != 16'hFFFF) ? upd_cnt_q + 16'd1 : upd_cnt_q;
    end
  end
  assign drop_count_o = drop_cnt_q;
  assign upd_count_o = upd_cnt_q;
`endif
endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb_bp_update_scheduler: directed checks of the clear walk, 2-wide enqueue, drops, flush and async reset.
module tb_bp_update_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] fb_valid, fb_taken, fb_mispredict;
  logic [1:0][31:0] fb_pc, fb_target;
  logic clear_req, pred_stall, drop_pulse;
  logic [3:0] fifo_count;
  int total = 0;
  int passed = 0;
`ifdef BP_UPD_STATS_EN
  logic [15:0] drop_count, upd_count;
`endif
  bp_update_scheduler_if #(.ADDR_WIDTH(32), .INDEX_BITS(3)) upd ();
  bp_update_scheduler #(.ADDR_WIDTH(32), .FIFO_DEPTH(8), .INDEX_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .fb_valid_i(fb_valid), .fb_pc_i(fb_pc), .fb_target_i(fb_target),
    .fb_taken_i(fb_taken), .fb_mispredict_i(fb_mispredict), .clear_req_i(clear_req),
    .upd(upd.master),
    .pred_stall_o(pred_stall), .drop_pulse_o(drop_pulse), .fifo_count_o(fifo_count)
`ifdef BP_UPD_STATS_EN
    , .drop_count_o(drop_count), .upd_count_o(upd_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fb(input logic [1:0] v, input logic [1:0] mp, input logic [31:0] p0, input logic [31:0] p1);
    fb_valid = v;
    fb_mispredict = mp;
    fb_pc[0] = p0;
    fb_pc[1] = p1;
    fb_target[0] = p0 + 32'h1000;
    fb_target[1] = p1 + 32'h1000;
  endtask
  initial begin
    rst_n = 1'b0;
    upd.ready = 1'b1;
    clear_req = 1'b0;
    fb_taken = 2'b00;
    fb(2'b00, 2'b00, 32'h0, 32'h0);
    #3;
    chk("rst_stall", pred_stall, 1);
    chk("rst_valid", upd.valid, 1);
    chk("rst_clear", upd.clear, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_drop", drop_pulse, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("walk_idx", upd.index, i);
      chk("walk_stall", pred_stall, 1);
      step();
    end
    chk("run_stall", pred_stall, 0);
    chk("run_clear", upd.clear, 0);
    chk("run_idx", upd.index, 0);
    chk("run_valid_empty", upd.valid, 0);
    // two slots in one cycle drain in order, one per cycle
    fb(2'b11, 2'b00, 32'h100, 32'h200);
    fb_taken = 2'b01;
    step();
    fb(2'b00, 2'b00, 32'h0, 32'h0);
    chk("pair_count2", fifo_count, 2);
    chk("pair_pc0", upd.pc, 32'h100);
    chk("pair_tgt0", upd.target, 32'h1100);
    chk("pair_taken0", upd.taken, 1);
    step();
    chk("pair_count1", fifo_count, 1);
    chk("pair_pc1", upd.pc, 32'h200);
    chk("pair_taken1", upd.taken, 0);
    step();
    chk("pair_count0", fifo_count, 0);
    chk("pair_valid0", upd.valid, 0);
    // slot 0 mispredict squashes slot 1 without a drop
    upd.ready = 1'b0;
    fb(2'b11, 2'b01, 32'h300, 32'h400);
    step();
    fb(2'b00, 2'b00, 32'h0, 32'h0);
    chk("squash_count", fifo_count, 1);
    chk("squash_drop", drop_pulse, 0);
    chk("squash_pc", upd.pc, 32'h300);
    upd.ready = 1'b1;
    step();
    chk("squash_drain", fifo_count, 0);
`ifdef BP_UPD_STATS_EN
    chk("upd_count", upd_count, 3);
`endif
    // fill to full with the port blocked, then overflow
    upd.ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fb(2'b11, 2'b00, 32'h1000 + 32'(k) * 32'h20, 32'h1010 + 32'(k) * 32'h20);
      step();
    end
    chk("full_count", fifo_count, 8);
    chk("full_head", upd.pc, 32'h1000);
    fb(2'b11, 2'b00, 32'hA00, 32'hB00);
    step();
    fb(2'b00, 2'b00, 32'h0, 32'h0);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_drop", drop_pulse, 1);
    chk("ovf_head", upd.pc, 32'h1000);
    chk("ovf_valid_held", upd.valid, 1);
    step();
    chk("ovf_drop_clear", drop_pulse, 0);
    // one free slot, pop and two pushes: slot 0 in, slot 1 dropped
    upd.ready = 1'b1;
    step();
    chk("seven_count", fifo_count, 7);
    chk("seven_head", upd.pc, 32'h1010);
    fb(2'b11, 2'b00, 32'hC00, 32'hD00);
    step();
    fb(2'b00, 2'b00, 32'h0, 32'h0);
    chk("part_count", fifo_count, 7);
    chk("part_drop", drop_pulse, 1);
    chk("part_head", upd.pc, 32'h1020);
`ifdef BP_UPD_STATS_EN
    chk("drop_count", drop_count, 3);
`endif
    for (int k = 0; k < 4; k++) step();
    chk("three_count", fifo_count, 3);
    chk("three_head", upd.pc, 32'h1060);
    // clear request flushes queue and discards same-cycle feedback silently
    clear_req = 1'b1;
    fb(2'b11, 2'b00, 32'hE00, 32'hF00);
    step();
    clear_req = 1'b0;
    fb(2'b00, 2'b00, 32'h0, 32'h0);
    chk("flush_stall", pred_stall, 1);
    chk("flush_clear", upd.clear, 1);
    chk("flush_idx", upd.index, 0);
    chk("flush_count", fifo_count, 0);
    chk("flush_drop", drop_pulse, 0);
    chk("flush_pc", upd.pc, 0);
    // enqueue during INIT; clear_req ignored; ready low holds the index
    fb(2'b01, 2'b00, 32'h777, 32'h0);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    fb(2'b00, 2'b00, 32'h0, 32'h0);
    chk("init_idx1", upd.index, 1);
    chk("init_count", fifo_count, 1);
    chk("init_pc_zero", upd.pc, 0);
    upd.ready = 1'b0;
    step();
    chk("init_hold", upd.index, 1);
    upd.ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("init_idx5", upd.index, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_idx", upd.index, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_stall", pred_stall, 1);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("rerun_stall", pred_stall, 0);
    chk("rerun_valid", upd.valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Funnels branch-resolution feedback (up to 2 per cycle from the execute slots) into the single write port shared by the BTB and gshare tables.
- Sits between the branch units and next_pc prediction storage; buffers updates in a FIFO.
- Owns the table-clear sequence after reset or a clear request; asserts pred_stall during it so next_pc_predictor falls back to sequential (+8) fetch.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- FIFO_DEPTH, 8, update queue entries; power of 2, >=2.
- INDEX_BITS, 9, table index width; clear walk covers 2^INDEX_BITS entries.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- fb_valid  input  2  per-slot feedback valid; slot 0 is older.
- fb_pc  input  2xADDR_WIDTH  branch PC per slot.
- fb_target  input  2xADDR_WIDTH  resolved target per slot.
- fb_taken  input  2  resolved direction per slot.
- fb_mispredict  input  2  slot's prediction was wrong (redirect issued).
- clear_req  input  1  request a full table clear (1-cycle pulse).
- upd_valid  output  1  write-port request.
- upd_ready  input  1  table accepts write this cycle.
- upd_clear  output  1  current request is a clear write (data fields 0).
- upd_index  output  INDEX_BITS  clear index; 0 when upd_clear=0.
- upd_pc  output  ADDR_WIDTH  update PC.
- upd_target  output  ADDR_WIDTH  update target.
- upd_taken  output  1  update direction.
- pred_stall  output  1  tables invalid; predictor must not use them.
- drop_pulse  output  1  >=1 feedback entry dropped this cycle.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
- States: INIT, RUN. Reset (async) -> INIT, clear_idx=0, FIFO empty, fifo_count=0, drop_pulse=0.
- INIT: upd_valid=1, upd_clear=1, upd_index=clear_idx, upd_pc/target/taken=0, pred_stall=1. On upd_valid&&upd_ready: clear_idx+1. Handshake at clear_idx=2^INDEX_BITS-1 -> RUN next cycle, clear_idx wraps to 0. clear_req ignored in INIT.
- RUN: pred_stall=0, upd_clear=0, upd_index=0. upd_valid=(fifo_count!=0); data = FIFO head. Pop on upd_valid&&upd_ready.
- RUN + clear_req: -> INIT next cycle, clear_idx=0, FIFO flushed (count=0); a same-cycle pop still completes; same-cycle feedback discarded without drop_pulse.
- Enqueue (INIT and RUN): slot 0 accepted if fb_valid[0]. Slot 1 accepted if fb_valid[1] && !(fb_valid[0]&&fb_mispredict[0]) (wrong path); squashed slot 1 is not a drop.
- Order: slot 0 enqueued before slot 1; FIFO strict order.
- Free space = FIFO_DEPTH - fifo_count (registered value); same-cycle pop does not free space.
- Space 1, two accepted -> slot 0 in, slot 1 dropped. Space 0 -> all dropped. drop_pulse registered, 1 cycle after the drop.
- Latency: entry enqueued at edge N appears at head from cycle N+1 if FIFO was empty.
- fifo_count = count + pushes - pop each cycle; never exceeds FIFO_DEPTH; pointers wrap mod FIFO_DEPTH.
- Outputs stable while upd_valid && !upd_ready.

Optional Feature:
- BP_UPD_STATS_EN defined: adds outputs drop_count[15:0] and upd_count[15:0]. Both saturate at 16'hFFFF, reset to 0, unaffected by clear_req. drop_count += entries dropped per cycle (0-2). upd_count += 1 per RUN-state pop.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- INIT_BITS=3, reset release, upd_ready=1 -> upd_clear=1, upd_index 0..7 on 8 cycles, pred_stall=0 and state RUN from cycle 9.
- RUN, fb_valid=2'b11, pcs 0x100/0x200, no mispredict, upd_ready=1 -> 0x100 at cycle+1, 0x200 at cycle+2; fifo_count 2 then 1 then 0.
- fb_valid=2'b11, fb_mispredict[0]=1 -> only slot 0 enqueued; fifo_count=1; drop_pulse=0.
- FIFO_DEPTH=8, upd_ready=0, push 2/cycle for 4 cycles, then push 2 more -> fifo_count=8, drop_pulse=1 next cycle, head still first entry.
- fifo_count=7, upd_ready=1 with pop, two pushes -> one accepted, one dropped; fifo_count=7.
- clear_req with 3 queued -> FIFO empty, INIT from index 0; async reset mid-INIT at idx 5 -> idx 0, outputs reset immediately.
